// File: rtl/mod_red_pipe.sv
// mod_red_pipe: pipelined word-level Montgomery reduction, C = P * 2^(-W_SIZE*L_SIZE) mod q.
// The modulus comes from a small runtime table and travels with its sample. A single global
// stall (adv) freezes every stage when the output is held.
// Optional build macro MODRED_CHK_EN adds the out_err port, which flags illegal table moduli.
module mod_red_pipe #(
    parameter int unsigned DATA_SIZE_ARB = 32,
    parameter int unsigned W_SIZE        = 12,
    parameter int unsigned L_SIZE        = 3,
    parameter int unsigned NUM_MOD       = 4,
    parameter int unsigned TAG_W         = 4,
    localparam int unsigned QSEL_W       = $clog2(NUM_MOD)
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       q_we,
    input  logic [QSEL_W-1:0]          q_waddr,
    input  logic [DATA_SIZE_ARB-1:0]   q_wdata,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [QSEL_W-1:0]          in_qsel,
    input  logic [TAG_W-1:0]           in_tag,
    input  logic [2*DATA_SIZE_ARB-1:0] P,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [TAG_W-1:0]           out_tag,
    output logic [DATA_SIZE_ARB-1:0]   C
`ifdef MODRED_CHK_EN
    ,
    output logic                       out_err
`endif
);

    localparam int unsigned D   = DATA_SIZE_ARB;
    localparam int unsigned TW  = 2 * DATA_SIZE_ARB;
    localparam int unsigned QHW = DATA_SIZE_ARB - W_SIZE;

    logic                adv;
    logic [D-1:0]        q_tab [NUM_MOD];
    logic [D-1:0]        q_sel;
    logic                v_q   [L_SIZE];
    logic [TAG_W-1:0]    tag_q [L_SIZE];
    logic [D-1:0]        qv_q  [L_SIZE];
    logic [TW-1:0]       t_q   [L_SIZE];
    logic [TW-1:0]       t_src [L_SIZE];
    logic [D-1:0]        q_src [L_SIZE];
    logic [TW-1:0]       t_nxt [L_SIZE];
    logic [D+1:0]        t_fin;
    logic [D+1:0]        c_t;
    logic [D-1:0]        c_nxt;

    assign adv      = !out_valid || out_ready;
    assign in_ready = adv && reset;
    // Combinational read: a same-edge write lands after this value is captured.
    assign q_sel    = q_tab[in_qsel];

    // Modulus table, cleared by reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < NUM_MOD; i++) q_tab[i] <= '0;
        end else if (q_we) begin
            q_tab[q_waddr] <= q_wdata;
        end
    end

    assign t_src[0] = P;
    assign q_src[0] = q_sel;
    for (genvar k = 1; k < L_SIZE; k++) begin : g_link
        assign t_src[k] = t_q[k-1];
        assign q_src[k] = qv_q[k-1];
    end

    // Each stage retires W_SIZE low bits. With q = qH*2^W + 1 and m = -T mod 2^W,
    // (T + m*q) >> W == (T >> W) + (T_low != 0) + m*qH, so no full-width q product is needed.
    for (genvar k = 0; k < L_SIZE; k++) begin : g_stage
        localparam int unsigned SW = (k == L_SIZE - 1) ? D + 2 : TW - (k + 1) * (W_SIZE - 1);
        localparam logic [TW-1:0] MASK = {TW{1'b1}} >> (TW - SW);
        logic [W_SIZE-1:0] m;
        logic [D-1:0]      mq;

        assign m        = -t_src[k][W_SIZE-1:0];
        assign mq       = {{QHW{1'b0}}, m} * {{W_SIZE{1'b0}}, q_src[k][D-1:W_SIZE]};
        assign t_nxt[k] = MASK & ({{W_SIZE{1'b0}}, t_src[k][TW-1:W_SIZE]}
                                  + {{(TW-1){1'b0}}, |t_src[k][W_SIZE-1:0]}
                                  + {{(TW-D){1'b0}}, mq});
    end

    // Reduction registers: valid, tag, latched modulus and partial value shift together on adv.
    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int k = 0; k < L_SIZE; k++) begin
                v_q[k]   <= 1'b0;
                tag_q[k] <= '0;
                qv_q[k]  <= '0;
                t_q[k]   <= '0;
            end
        end else if (adv) begin
            v_q[0]   <= in_valid;
            tag_q[0] <= in_tag;
            for (int k = 1; k < L_SIZE; k++) begin
                v_q[k]   <= v_q[k-1];
                tag_q[k] <= tag_q[k-1];
            end
            for (int k = 0; k < L_SIZE; k++) begin
                qv_q[k] <= q_src[k];
                t_q[k]  <= t_nxt[k];
            end
        end
    end

    // Final conditional subtraction; last stage value is below 2q.
    assign t_fin = t_q[L_SIZE-1][D+1:0];
    assign c_t   = t_fin - {2'b00, qv_q[L_SIZE-1]};
    assign c_nxt = c_t[D+1] ? t_fin[D-1:0] : c_t[D-1:0];

    // Output register, held while the consumer stalls.
    always_ff @(posedge clk) begin
        if (!reset) begin
            out_valid <= 1'b0;
            out_tag   <= '0;
            C         <= '0;
        end else if (adv) begin
            out_valid <= v_q[L_SIZE-1];
            out_tag   <= tag_q[L_SIZE-1];
            C         <= c_nxt;
        end
    end

`ifdef MODRED_CHK_EN
    logic err_in;
    logic err_q [L_SIZE];

    assign err_in = (q_sel[W_SIZE-1:0] != W_SIZE'(1)) || (q_sel == '0);

    // Illegal-modulus flag rides alongside its sample and lands with C.
    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int k = 0; k < L_SIZE; k++) err_q[k] <= 1'b0;
            out_err <= 1'b0;
        end else if (adv) begin
            err_q[0] <= err_in;
            for (int k = 1; k < L_SIZE; k++) err_q[k] <= err_q[k-1];
            out_err <= err_q[L_SIZE-1];
        end
    end
`endif

endmodule

// File: tb/tb_mod_red_pipe.sv
// Directed bench for mod_red_pipe: hand-computed vectors plus a modular reference
// C = (P mod q) * (2^-36 mod q) mod q, where 2^-12 == q - qH (mod q).
module tb_mod_red_pipe;

    localparam logic [31:0] Q0  = 32'hFFF0_0001;
    localparam logic [31:0] Q1  = 32'h7FFF_F001;
    localparam logic [31:0] Q1B = 32'h0FFF_F001;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        q_we = 1'b0;
    logic [1:0]  q_waddr = '0;
    logic [31:0] q_wdata = '0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [1:0]  in_qsel = '0;
    logic [3:0]  in_tag = '0;
    logic [63:0] P = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [3:0]  out_tag;
    logic [31:0] C;
`ifdef MODRED_CHK_EN
    logic        out_err;
`endif

    mod_red_pipe dut (
        .clk       (clk),
        .reset     (reset),
        .q_we      (q_we),
        .q_waddr   (q_waddr),
        .q_wdata   (q_wdata),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_qsel   (in_qsel),
        .in_tag    (in_tag),
        .P         (P),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_tag   (out_tag),
        .C         (C)
`ifdef MODRED_CHK_EN
        ,
        .out_err   (out_err)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] p;
        logic [1:0]  qsel;
        logic [3:0]  tag;
        bit          has_exp;
        logic [31:0] exp_c;
    } item_t;

    typedef struct {
        logic [31:0] c;
        logic [3:0]  tag;
        bit          chk_c;
        bit          err;
        int          acc;
    } exp_t;

    item_t       in_q [$];
    exp_t        sb [$];
    logic [31:0] tab_m [4] = '{default: '0};
    int          n_vec = 0;
    int          n_bad = 0;
    int          cyc = 0;
    int          n_out = 0;
    bit          lat_chk = 0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s @cyc %0d: got %h, want %h", name, cyc, got, exp);
        end
    endtask

    function automatic logic [31:0] ref_c(input logic [63:0] p, input logic [31:0] q);
        longint unsigned qq, ri, r, pm;
        qq = 64'(q);
        ri = qq - 64'(q >> 12);
        r  = (ri * ri) % qq;
        r  = (r * ri) % qq;
        pm = p % qq;
        return 32'((pm * r) % qq);
    endfunction

    function automatic bit legal(input logic [31:0] q);
        return (q[11:0] == 12'h001) && (q != 32'h0);
    endfunction

    task automatic add(input logic [63:0] p, input logic [1:0] s, input logic [3:0] t,
                       input bit he, input logic [31:0] e);
        item_t it;
        it.p = p; it.qsel = s; it.tag = t; it.has_exp = he; it.exp_c = e;
        in_q.push_back(it);
    endtask

    // One clock: drive, sample just before the edge, update the model, wait for next negedge.
    task automatic step();
        exp_t e;
        if (in_q.size() > 0) begin
            in_valid = 1'b1;
            P        = in_q[0].p;
            in_qsel  = in_q[0].qsel;
            in_tag   = in_q[0].tag;
        end else begin
            in_valid = 1'b0;
        end
        #1;
        if (out_valid && out_ready) begin
            if (sb.size() == 0) begin
                check("stray_out", 64'(out_valid), 64'(0));
            end else begin
                e = sb.pop_front();
                if (e.chk_c) check("c", 64'(C), 64'(e.c));
                check("tag", 64'(out_tag), 64'(e.tag));
                if (lat_chk) check("latency", 64'(cyc - e.acc), 64'(4));
`ifdef MODRED_CHK_EN
                check("err", 64'(out_err), 64'(e.err));
`endif
                n_out++;
            end
        end
        if (in_valid && in_ready) begin
            e.c     = in_q[0].has_exp ? in_q[0].exp_c : ref_c(in_q[0].p, tab_m[in_q[0].qsel]);
            e.tag   = in_q[0].tag;
            e.chk_c = legal(tab_m[in_q[0].qsel]);
            e.err   = !legal(tab_m[in_q[0].qsel]);
            e.acc   = cyc;
            sb.push_back(e);
            void'(in_q.pop_front());
        end
        if (q_we) tab_m[q_waddr] = q_wdata;
        if (!reset) begin
            for (int i = 0; i < 4; i++) tab_m[i] = '0;
            sb.delete();
        end
        @(negedge clk);
        cyc++;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((sb.size() > 0 || in_q.size() > 0) && n < 300) begin
            step();
            n++;
        end
        check("drain", 64'(sb.size() + in_q.size()), 64'(0));
    endtask

    task automatic write_q(input logic [1:0] a, input logic [31:0] d);
        q_we = 1'b1; q_waddr = a; q_wdata = d;
        step();
        q_we = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, want finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] c_hold;
        logic [3:0]  t_hold;
        int          c0;
        int          n0;

        // Reset state
        @(negedge clk);
        @(negedge clk);
        #1;
        check("rst_ov", 64'(out_valid), 64'(0));
        check("rst_rdy", 64'(in_ready), 64'(0));
        check("rst_c", 64'(C), 64'(0));
        check("rst_tag", 64'(out_tag), 64'(0));
        @(negedge clk);
        reset = 1'b1;
        write_q(2'd0, Q0);

        // Directed vectors with exact latency
        lat_chk = 1;
        add(64'h0, 2'd0, 4'd1, 1, 32'd0);
        drain();
        add(64'(Q0), 2'd0, 4'd2, 1, 32'd0);
        drain();
        add(64'h0000_0000_00FF_FFF0, 2'd0, 4'd3, 1, 32'd1);
        drain();
        lat_chk = 0;

        // Back-to-back stream with model
        c0 = cyc;
        add(64'(Q0) * 64'(Q0) - 64'd1, 2'd0, 4'd0, 0, 32'd0);
        add(64'(Q0) - 64'd1, 2'd0, 4'd1, 0, 32'd0);
        for (int i = 2; i < 120; i++)
            add({$urandom(), $urandom()} % (64'(Q0) * 64'(Q0)), 2'd0, 4'(i), 0, 32'd0);
        drain();
        check("thru", 64'(cyc - c0), 64'(124));

        // Stall in the middle of a burst
        for (int i = 0; i < 8; i++)
            add({$urandom(), $urandom()} % (64'(Q0) * 64'(Q0)), 2'd0, 4'(i + 8), 0, 32'd0);
        for (int i = 0; i < 12; i++) begin
            out_ready = !(i >= 6 && i < 11);
            #1;
            if (i == 6) begin
                c_hold = C;
                t_hold = out_tag;
            end
            if (!out_ready) begin
                check("stall_rdy", 64'(in_ready), 64'(0));
                check("stall_ov", 64'(out_valid), 64'(1));
                if (i > 6) begin
                    check("stall_c", 64'(C), 64'(c_hold));
                    check("stall_tag", 64'(out_tag), 64'(t_hold));
                end
            end
            step();
        end
        out_ready = 1'b1;
        drain();

        // Two moduli interleaved, entry 1 rewritten mid-flight
        write_q(2'd1, Q1);
        add(64'h1_FFE0, 2'd1, 4'd4, 1, 32'd1);
        add(64'(Q1), 2'd1, 4'd5, 1, 32'd0);
        for (int i = 0; i < 8; i++)
            add({$urandom(), $urandom()} % (64'(Q1B) * 64'(Q1B)), 2'(i % 2), 4'(i), 0, 32'd0);
        repeat (4) step();
        q_we = 1'b1; q_waddr = 2'd1; q_wdata = Q1B;
        step();
        q_we = 1'b0;
        add(64'h000F_FF00, 2'd1, 4'd6, 1, 32'd1);
        for (int i = 0; i < 4; i++)
            add({$urandom(), $urandom()} % (64'(Q1B) * 64'(Q1B)), 2'(i % 2), 4'(i), 0, 32'd0);
        drain();

        // Reset with samples in flight
        for (int i = 0; i < 5; i++) add(64'(i * 1000 + 7), 2'd0, 4'(i), 0, 32'd0);
        repeat (5) step();
        reset = 1'b0;
        step();
        #1;
        check("mid_rst_ov", 64'(out_valid), 64'(0));
        check("mid_rst_c", 64'(C), 64'(0));
        check("mid_rst_rdy", 64'(in_ready), 64'(0));
        reset = 1'b1;
        n0 = n_out;
        repeat (10) step();
        check("stale_cnt", 64'(n_out - n0), 64'(0));
`ifdef MODRED_CHK_EN
        add(64'd5, 2'd0, 4'd9, 0, 32'd0);
        drain();
`endif
        write_q(2'd0, Q0);
        add(64'h0000_0000_00FF_FFF0, 2'd0, 4'd10, 1, 32'd1);
        drain();

`ifdef MODRED_CHK_EN
        // Illegal modulus flag
        write_q(2'd2, 32'h0000_1000);
        add(64'd12345, 2'd2, 4'd11, 0, 32'd0);
        add(64'd12345, 2'd0, 4'd12, 0, 32'd0);
        drain();
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
